// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the register-file read arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default register address / data widths
//   REG_ZERO                : architectural zero register number
//   rsp_t                   : response record {id, data} for downstream clients
package regfile_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;
  // Wide enough for the largest supported requester count (8).
  localparam int unsigned ID_W_MAX   = 3;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [ID_W_MAX-1:0]   id;
    logic [DATA_W_DEF-1:0] data;
  } rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req    in   NUM_REQ            request vector
//   ptr    in   $clog2(NUM_REQ)    highest-priority requester this cycle
//   gnt    out  NUM_REQ            one-hot grant (all 0 when no request)
//   gnt_id out  $clog2(NUM_REQ)    index of granted requester
//   any    out  1                  at least one request present
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       any
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  int unsigned idx;

  // Scan from ptr upward, wrapping, and take the first valid requester.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = (32'(ptr) + off) % NUM_REQ;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IdW'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares one register-file read port among NUM_REQ requesters.
// Round-robin grant with valid/ready handshake, a registered select stage (A)
// driving the read mux, and a registered response stage (R).
// Build option: REGFILE_ARB_BYPASS_EN forwards a same-cycle register-file write
// to the response when it targets the register being read.
//   Clk        in   clock
//   Rst        in   asynchronous active-high reset
//   req_valid  in   per-requester read request
//   req_addr   in   per-requester register number, requester i at [i*ADDR_W +: ADDR_W]
//   req_ready  out  one-hot grant
//   S          out  registered select to read mux
//   Y          in   read mux data for S
//   wr_en/wr_addr/wr_data  in  register-file write port snoop (bypass only)
//   rsp_valid/rsp_id/rsp_data  out  response; rsp_ready in  consumer accept
module regfile_read_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [ADDR_W-1:0]           S,
  input  logic [DATA_W-1:0]           Y,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic [DATA_W-1:0]           rsp_data,
  input  logic                        rsp_ready
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  // Pipeline state
  logic              sel_valid_q;
  logic [ADDR_W-1:0] s_q;
  logic [IdW-1:0]    sel_id_q;
  logic              rsp_valid_q;
  logic [IdW-1:0]    rsp_id_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [IdW-1:0]    ptr_q;

  logic [NUM_REQ-1:0] gnt;
  logic [IdW-1:0]     win_id;
  logic               any_req;
  logic               advance;
  logic               accept;
  logic [ADDR_W-1:0]  win_addr;
  logic [IdW-1:0]     ptr_next;
  logic [DATA_W-1:0]  rd_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req    (req_valid),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_id (win_id),
    .any    (any_req)
  );

  // Both stages move together; a stalled response freezes everything.
  assign advance   = !rsp_valid_q || rsp_ready;
  assign accept    = advance && any_req && !Rst;
  assign req_ready = (advance && !Rst) ? gnt : '0;
  assign win_addr  = req_addr[32'(win_id)*ADDR_W +: ADDR_W];
  assign ptr_next  = (32'(win_id) == NUM_REQ - 1) ? '0 : win_id + 1'b1;

  // Value captured into the response on the R-load edge.
  always_comb begin
    rd_data = Y;
    if (s_q == ADDR_W'(REG_ZERO)) begin
      rd_data = '0;
    end
`ifdef REGFILE_ARB_BYPASS_EN
    else if (wr_en && (wr_addr == s_q)) begin
      rd_data = wr_data;
    end
`endif
  end

`ifndef REGFILE_ARB_BYPASS_EN
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sel_valid_q <= 1'b0;
      s_q         <= '0;
      sel_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      ptr_q       <= '0;
    end else if (advance) begin
      sel_valid_q <= accept;
      // S only changes on an accept so the read mux stays quiet when idle.
      if (accept) begin
        s_q      <= win_addr;
        sel_id_q <= win_id;
        ptr_q    <= ptr_next;
      end
      rsp_valid_q <= sel_valid_q;
      if (sel_valid_q) begin
        rsp_id_q   <= sel_id_q;
        rsp_data_q <= rd_data;
      end
    end
  end

  assign S         = s_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed self-checking bench for regfile_read_arbiter (NUM_REQ=4).
// Read mux model: register n holds n*0x11 unless Y is forced.
module tb_regfile_read_arbiter;

  logic        Clk;
  logic        Rst;
  logic [3:0]  req_valid;
  logic [19:0] req_addr;
  logic [3:0]  req_ready;
  logic [4:0]  S;
  logic [31:0] Y;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_ready;

  logic        y_force;
  logic [31:0] y_force_val;

  int tests;
  int fails;

  regfile_read_arbiter #(
    .NUM_REQ (4),
    .ADDR_W  (5),
    .DATA_W  (32)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .S         (S),
    .Y         (Y),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always_comb begin
    Y = y_force ? y_force_val : ({27'd0, S} * 32'h11);
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
  endtask

  task automatic set_addr(input int i, input logic [4:0] a);
    req_addr[i*5 +: 5] = a;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    req_valid = 4'hF;
    #2;
    tests++;
    if (req_ready !== 4'b0000) begin
      fails++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready);
    end
    tests++;
    if (S !== 5'd0 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 32'd0) begin
      fails++;
      $display("FAIL reset_outputs S=%0d rsp_valid=%b rsp_id=%0d rsp_data=%h exp all 0",
               S, rsp_valid, rsp_id, rsp_data);
    end
    step();
    Rst = 1'b0;
    req_valid = 4'h0;
  endtask

  task automatic test_single_read();
    do_reset();
    rsp_ready = 1'b1;
    set_addr(0, 5'd5);
    req_valid = 4'b0001;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++; $display("FAIL single_grant got=%b exp=0001", req_ready);
    end
    step();
    req_valid = 4'b0000;
    tests++;
    if (S !== 5'd5 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL single_select S=%0d rsp_valid=%b exp S=5 rsp_valid=0", S, rsp_valid);
    end
    step();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'h00000055) begin
      fails++;
      $display("FAIL single_rsp valid=%b id=%0d data=%h exp 1/0/00000055",
               rsp_valid, rsp_id, rsp_data);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_addr(i, 5'(i + 1));
    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (k < 5) begin
        tests++;
        if (req_ready !== 4'(1 << (k % 4))) begin
          fails++;
          $display("FAIL b2b_grant k=%0d got=%b exp=%b", k, req_ready, 4'(1 << (k % 4)));
        end
      end
      step();
      if (k == 4) req_valid = 4'h0;
      if (k < 5) begin
        tests++;
        if (S !== 5'((k % 4) + 1)) begin
          fails++; $display("FAIL b2b_select k=%0d S=%0d exp=%0d", k, S, (k % 4) + 1);
        end
      end
      if (k >= 1) begin
        tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'((k - 1) % 4) ||
            rsp_data !== 32'(((k - 1) % 4 + 1) * 32'h11)) begin
          fails++;
          $display("FAIL b2b_rsp k=%0d valid=%b id=%0d data=%h exp 1/%0d/%h", k, rsp_valid,
                   rsp_id, rsp_data, (k - 1) % 4, ((k - 1) % 4 + 1) * 32'h11);
        end
      end
    end
    step();
    tests++;
    if (rsp_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_drain rsp_valid=%b exp=0", rsp_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) set_addr(i, 5'(i + 1));
    req_valid = 4'hF;
    step();
    step();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'h11 || S !== 5'd2) begin
      fails++;
      $display("FAIL bp_fill valid=%b id=%0d data=%h S=%0d exp 1/0/00000011/2",
               rsp_valid, rsp_id, rsp_data, S);
    end
    for (int c = 0; c < 3; c++) begin
      tests++;
      if (req_ready !== 4'b0000) begin
        fails++; $display("FAIL bp_no_grant c=%0d got=%b exp=0000", c, req_ready);
      end
      step();
      tests++;
      if (S !== 5'd2 || rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'h11) begin
        fails++;
        $display("FAIL bp_hold c=%0d S=%0d valid=%b id=%0d data=%h exp 2/1/0/00000011",
                 c, S, rsp_valid, rsp_id, rsp_data);
      end
    end
    rsp_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0100) begin
      fails++; $display("FAIL bp_resume_grant got=%b exp=0100", req_ready);
    end
    step();
    req_valid = 4'h0;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 32'h22 || S !== 5'd3) begin
      fails++;
      $display("FAIL bp_resume1 valid=%b id=%0d data=%h S=%0d exp 1/1/00000022/3",
               rsp_valid, rsp_id, rsp_data, S);
    end
    step();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'h33) begin
      fails++;
      $display("FAIL bp_resume2 valid=%b id=%0d data=%h exp 1/2/00000033",
               rsp_valid, rsp_id, rsp_data);
    end
    step();
  endtask

  task automatic test_reg_zero();
    do_reset();
    rsp_ready = 1'b1;
    y_force = 1'b1;
    y_force_val = 32'hDEADBEEF;
    set_addr(1, 5'd0);
    req_valid = 4'b0010;
    step();
    req_valid = 4'b0000;
    step();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 32'h0) begin
      fails++;
      $display("FAIL r0_rsp valid=%b id=%0d data=%h exp 1/1/00000000", rsp_valid, rsp_id, rsp_data);
    end
    y_force = 1'b0;
  endtask

  task automatic test_bypass();
    logic [31:0] exp_fwd;
`ifdef REGFILE_ARB_BYPASS_EN
    exp_fwd = 32'h00001234;
`else
    exp_fwd = 32'h00000001;
`endif
    do_reset();
    rsp_ready = 1'b1;
    y_force = 1'b1;
    y_force_val = 32'h1;
    // Matching write on the R-load edge.
    set_addr(0, 5'd7);
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h00001234;
    step();
    wr_en = 1'b0;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== exp_fwd) begin
      fails++; $display("FAIL bypass_hit valid=%b data=%h exp 1/%h", rsp_valid, rsp_data, exp_fwd);
    end
    // Write to a different register never forwards.
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;
    wr_en = 1'b1; wr_addr = 5'd6;
    step();
    wr_en = 1'b0;
    tests++;
    if (rsp_data !== 32'h1) begin
      fails++; $display("FAIL bypass_miss data=%h exp 00000001", rsp_data);
    end
    // Write to r0 never forwards.
    set_addr(0, 5'd0);
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;
    wr_en = 1'b1; wr_addr = 5'd0;
    step();
    wr_en = 1'b0;
    tests++;
    if (rsp_data !== 32'h0) begin
      fails++; $display("FAIL bypass_r0 data=%h exp 00000000", rsp_data);
    end
    y_force = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) set_addr(i, 5'(i + 1));
    req_valid = 4'b0010;
    step();
    req_valid = 4'b0000;
    step();
    req_valid = 4'hF;
    #1;
    tests++;
    if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin
      fails++;
      $display("FAIL arst_setup valid=%b req_ready=%b exp 1/0000", rsp_valid, req_ready);
    end
    Rst = 1'b1;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || S !== 5'd0) begin
      fails++; $display("FAIL arst_clear valid=%b S=%0d exp 0/0", rsp_valid, S);
    end
    Rst = 1'b0;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++; $display("FAIL arst_ptr got=%b exp=0001", req_ready);
    end
    step();
    req_valid = 4'h0;
    tests++;
    if (S !== 5'd1 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL arst_next S=%0d valid=%b exp 1/0", S, rsp_valid);
    end
    rsp_ready = 1'b1;
    step();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    Rst = 1'b0;
    req_valid = '0;
    req_addr = '0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rsp_ready = 1'b1;
    y_force = 1'b0;
    y_force_val = '0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_backpressure();
    test_reg_zero();
    test_bypass();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
